// File: rtl/cube_move_engine.sv
// Registered cube-state engine: queues incoming moves in a FIFO and applies one clockwise
// quarter turn per clock. Also provides bulk load, solved detection and a completed-move counter.
module cube_move_engine #(
    parameter int COLOR_W    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_resetN,
    input  logic                  i_moveValid,
    output logic                  o_moveReady,
    input  logic [2:0]            i_moveFace,
    input  logic [1:0]            i_moveTurns,
    input  logic                  i_loadValid,
    output logic                  o_loadReady,
    input  logic [54*COLOR_W-1:0] i_loadState,
    output logic [54*COLOR_W-1:0] o_cubeState,
    output logic                  o_busy,
    output logic                  o_solvedFlag,
    output logic                  o_errInvalid,
    output logic [CNT_W-1:0]      o_moveCount
);
    localparam int STATE_W = 54 * COLOR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    // Five 4-cycles per face; cycle (a b c d): new[a]=old[b], new[b]=old[c], new[c]=old[d], new[d]=old[a]
    localparam int CYC [0:119] = '{
        0, 6, 8, 2,     20, 29, 38, 11,  18, 27, 36, 9,   1, 3, 7, 5,      19, 28, 37, 10,
        9, 15, 17, 11,  0, 44, 45, 18,   6, 38, 51, 24,   10, 12, 16, 14,  3, 41, 48, 21,
        18, 24, 26, 20, 6, 17, 47, 27,   8, 11, 45, 33,   19, 21, 25, 23,  7, 14, 46, 30,
        27, 33, 35, 29, 8, 26, 53, 36,   20, 47, 42, 2,   28, 30, 34, 32,  5, 23, 50, 39,
        36, 42, 44, 38, 29, 53, 15, 0,   2, 35, 51, 9,    37, 39, 43, 41,  1, 32, 52, 12,
        45, 51, 53, 47, 24, 15, 42, 33,  17, 44, 35, 26,  46, 48, 52, 50,  25, 16, 43, 34
    };

    function automatic logic [STATE_W-1:0] solved_state();
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < 54; i++) begin
            s[COLOR_W*i +: COLOR_W] = COLOR_W'(i / 9);
        end
        return s;
    endfunction

    function automatic logic [STATE_W-1:0] quarter_turn(input logic [STATE_W-1:0] s,
                                                        input logic [2:0] f);
        logic [STATE_W-1:0] n;
        int b;
        n = s;
        if (f < 3'd6) begin
            for (int c = 0; c < 5; c++) begin
                b = 20 * int'(f) + 4 * c;
                n[COLOR_W*CYC[b]   +: COLOR_W] = s[COLOR_W*CYC[b+1] +: COLOR_W];
                n[COLOR_W*CYC[b+1] +: COLOR_W] = s[COLOR_W*CYC[b+2] +: COLOR_W];
                n[COLOR_W*CYC[b+2] +: COLOR_W] = s[COLOR_W*CYC[b+3] +: COLOR_W];
                n[COLOR_W*CYC[b+3] +: COLOR_W] = s[COLOR_W*CYC[b]   +: COLOR_W];
            end
        end
        return n;
    endfunction

    localparam logic [STATE_W-1:0] SOLVED = solved_state();

    typedef enum logic {
        IDLE = 1'b0,
        TURN = 1'b1
    } state_t;

    state_t             r_state;
    logic [STATE_W-1:0] r_cube;
    logic [2:0]         r_face;
    logic [1:0]         r_rem;
    logic               r_err;
    logic [CNT_W-1:0]   r_move_count;
    logic [4:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic [4:0]         w_head;
    logic [STATE_W-1:0] w_turned;
    logic               w_solved;

    assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_moveValid && !w_full;
    assign w_pop   = (r_state == IDLE) && !w_empty;
    assign w_head  = r_fifo[r_rd_ptr];

    assign o_moveReady = !w_full;
    assign o_busy      = (r_state == TURN) || !w_empty;
    assign o_loadReady = !o_busy;
    assign w_load      = i_loadValid && !o_busy;

    assign o_cubeState  = r_cube;
    assign o_errInvalid = r_err;
    assign o_moveCount  = r_move_count;
    assign o_solvedFlag = w_solved;

    always_comb begin
        w_turned = quarter_turn(r_cube, r_face);
    end

    always_comb begin
        w_solved = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 9; k++) begin
                if (r_cube[COLOR_W*(9*f+k) +: COLOR_W] != r_cube[COLOR_W*(9*f+4) +: COLOR_W]) begin
                    w_solved = 1'b0;
                end
            end
        end
    end

    // FIFO storage carries no reset; the pointers and count define its contents.
    always_ff @(posedge i_clk) begin
        if (i_resetN && w_push) begin
            r_fifo[r_wr_ptr] <= {i_moveFace, i_moveTurns};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state      <= IDLE;
            r_cube       <= SOLVED;
            r_face       <= 3'd0;
            r_rem        <= 2'd0;
            r_err        <= 1'b0;
            r_move_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_cube       <= i_loadState;
                        r_move_count <= '0;
                        r_err        <= 1'b0;
                    end else if (w_pop) begin
                        if (w_head[4:2] > 3'd5) begin
                            r_err <= 1'b1;
                        end else if (w_head[1:0] != 2'd0) begin
                            r_face  <= w_head[4:2];
                            r_rem   <= w_head[1:0];
                            r_state <= TURN;
                        end
                    end
                end
                TURN: begin
                    r_cube <= w_turned;
                    r_rem  <= r_rem - 2'd1;
                    if (r_rem == 2'd1) begin
                        r_state <= IDLE;
                        if (r_move_count != '1) begin
                            r_move_count <= r_move_count + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cube_move_engine.sv
// Directed bench for cube_move_engine: hand-computed facelet checks plus an independent
// facelet-permutation model built from the quarter-turn table.
module tb_cube_move_engine;
    localparam int W  = 3;
    localparam int SW = 54 * W;

    logic          clk = 1'b0;
    logic          resetN;
    logic          moveValid;
    logic          moveReady;
    logic [2:0]    moveFace;
    logic [1:0]    moveTurns;
    logic          loadValid;
    logic          loadReady;
    logic [SW-1:0] loadState;
    logic [SW-1:0] cubeState;
    logic          busy;
    logic          solvedFlag;
    logic          errInvalid;
    logic [15:0]   moveCount;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic          saw_full;
    logic [SW-1:0] model;
    logic [SW-1:0] solved;
    logic [SW-1:0] pat;

    int TBL [6][20] = '{
        '{0, 6, 8, 2,     20, 29, 38, 11,  18, 27, 36, 9,   1, 3, 7, 5,      19, 28, 37, 10},
        '{9, 15, 17, 11,  0, 44, 45, 18,   6, 38, 51, 24,   10, 12, 16, 14,  3, 41, 48, 21},
        '{18, 24, 26, 20, 6, 17, 47, 27,   8, 11, 45, 33,   19, 21, 25, 23,  7, 14, 46, 30},
        '{27, 33, 35, 29, 8, 26, 53, 36,   20, 47, 42, 2,   28, 30, 34, 32,  5, 23, 50, 39},
        '{36, 42, 44, 38, 29, 53, 15, 0,   2, 35, 51, 9,    37, 39, 43, 41,  1, 32, 52, 12},
        '{45, 51, 53, 47, 24, 15, 42, 33,  17, 44, 35, 26,  46, 48, 52, 50,  25, 16, 43, 34}
    };

    cube_move_engine dut (
        .i_clk        (clk),
        .i_resetN     (resetN),
        .i_moveValid  (moveValid),
        .o_moveReady  (moveReady),
        .i_moveFace   (moveFace),
        .i_moveTurns  (moveTurns),
        .i_loadValid  (loadValid),
        .o_loadReady  (loadReady),
        .i_loadState  (loadState),
        .o_cubeState  (cubeState),
        .o_busy       (busy),
        .o_solvedFlag (solvedFlag),
        .o_errInvalid (errInvalid),
        .o_moveCount  (moveCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] fl(input logic [SW-1:0] s, input int i);
        return s[W*i +: W];
    endfunction

    // Reference model: one permutation step built by explicit gather from the old state.
    task automatic model_apply(input int face, input int turns);
        logic [SW-1:0] o;
        for (int t = 0; t < turns; t++) begin
            o = model;
            for (int c = 0; c < 5; c++) begin
                model[W*TBL[face][4*c]   +: W] = o[W*TBL[face][4*c+1] +: W];
                model[W*TBL[face][4*c+1] +: W] = o[W*TBL[face][4*c+2] +: W];
                model[W*TBL[face][4*c+2] +: W] = o[W*TBL[face][4*c+3] +: W];
                model[W*TBL[face][4*c+3] +: W] = o[W*TBL[face][4*c]   +: W];
            end
        end
    endtask

    task automatic push(input logic [2:0] f, input logic [1:0] t);
        int g = 0;
        moveFace  = f;
        moveTurns = t;
        moveValid = 1'b1;
        while (!moveReady && g < 200) begin
            saw_full = 1'b1;
            @(negedge clk);
            g++;
        end
        if (!moveReady) chk("push_timeout", {161'd0, moveReady}, 1);
        @(posedge clk);
        @(negedge clk);
        moveValid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("idle_timeout", {161'd0, busy}, 0);
    endtask

    task automatic load(input logic [SW-1:0] p);
        loadState = p;
        loadValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        loadValid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 54; i++) solved[W*i +: W] = 3'(i / 9);
        resetN    = 1'b0;
        moveValid = 1'b0;
        moveFace  = 3'd0;
        moveTurns = 2'd0;
        loadValid = 1'b0;
        loadState = '0;
        saw_full  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_state", cubeState, solved);
        chk("rst_solved", solvedFlag, 1);
        chk("rst_ready", moveReady, 1);
        chk("rst_loadready", loadReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", errInvalid, 0);
        chk("rst_count", moveCount, 0);
        resetN = 1'b1;
        @(negedge clk);

        // Single U: latency check
        moveFace = 3'd0; moveTurns = 2'd1; moveValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        moveValid = 1'b0;
        chk("u1_busy_t", busy, 1);
        chk("u1_f20_t", fl(cubeState, 20), 2);
        @(negedge clk);
        chk("u1_f20_t1", fl(cubeState, 20), 2);
        @(negedge clk);
        chk("u1_f20", fl(cubeState, 20), 3);
        chk("u1_f9", fl(cubeState, 9), 2);
        chk("u1_f0", fl(cubeState, 0), 0);
        chk("u1_solved", solvedFlag, 0);
        chk("u1_count", moveCount, 1);
        chk("u1_busy", busy, 0);
        model = solved; model_apply(0, 1);
        chk("u1_state", cubeState, model);

        // F' then F
        load(solved);
        chk("ld_count", moveCount, 0);
        chk("ld_state", cubeState, solved);
        push(3'd2, 2'd3);
        push(3'd2, 2'd1);
        wait_idle();
        chk("ff_state", cubeState, solved);
        chk("ff_solved", solvedFlag, 1);
        chk("ff_count", moveCount, 2);

        load(solved);
        for (int k = 0; k < 4; k++) push(3'd3, 2'd1);
        wait_idle();
        chk("r4_state", cubeState, solved);
        chk("r4_count", moveCount, 4);

        // Mixed sequence against the model
        load(solved);
        model = solved;
        push(3'd1, 2'd1); model_apply(1, 1);
        push(3'd4, 2'd2); model_apply(4, 2);
        push(3'd5, 2'd3); model_apply(5, 3);
        push(3'd0, 2'd1); model_apply(0, 1);
        wait_idle();
        chk("mix_state", cubeState, model);
        chk("mix_solved", solvedFlag, 0);
        chk("mix_count", moveCount, 4);

        // Twelve back-to-back R' fill the FIFO
        load(solved);
        model = solved;
        saw_full = 1'b0;
        for (int k = 0; k < 12; k++) begin
            push(3'd3, 2'd3);
            model_apply(3, 3);
        end
        wait_idle();
        chk("r36_full_seen", saw_full, 1);
        chk("r36_state_model", cubeState, model);
        chk("r36_state", cubeState, solved);
        chk("r36_count", moveCount, 12);

        // Invalid face and zero-turn move
        push(3'd7, 2'd1);
        push(3'd5, 2'd0);
        wait_idle();
        chk("inv_err", errInvalid, 1);
        chk("inv_state", cubeState, solved);
        chk("inv_count", moveCount, 12);
        load(solved);
        chk("inv_clr_err", errInvalid, 0);
        chk("inv_clr_count", moveCount, 0);

        // Load while busy is ignored
        model = solved;
        push(3'd3, 2'd3); model_apply(3, 3);
        chk("busy_loadready", loadReady, 0);
        load('0);
        wait_idle();
        chk("busy_load_ign", cubeState, model);
        chk("busy_load_cnt", moveCount, 1);

        for (int i = 0; i < 54; i++) pat[W*i +: W] = 3'(i % 6);
        load(pat);
        chk("ld_pat", cubeState, pat);
        chk("ld_pat_solved", solvedFlag, 0);
        for (int i = 0; i < 54; i++) pat[W*i +: W] = 3'(5 - i / 9);
        load(pat);
        chk("ld_alt_solved", solvedFlag, 1);

        // Reset mid-turn with moves queued
        load(solved);
        push(3'd3, 2'd3);
        push(3'd0, 2'd2);
        push(3'd1, 2'd1);
        push(3'd2, 2'd1);
        chk("mid_busy", busy, 1);
        resetN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_state", cubeState, solved);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", moveReady, 1);
        chk("mid_rst_count", moveCount, 0);
        resetN = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_state", cubeState, solved);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
